// File: rtl/risc5_sram16_ctrl.sv
// risc5_sram16_ctrl: RISC5 data-bus responder backed by an asynchronous 16-bit SRAM.
// Words take two half-accesses (low half first), bytes take one; stallX holds the
// CPU for the duration. All outputs except io_sel are registered.
// Optional feature macro: RISC5_SRAM_IO_BYPASS_EN (adds io_sel, keeps IO-page
// requests off the SRAM).
module risc5_sram16_ctrl #(
    parameter int unsigned ADR_W       = 19,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [23:0]      adr,
    input  logic             rd,
    input  logic             wr,
    input  logic             ben,
    input  logic [31:0]      outbus,
    output logic [31:0]      inbus,
    output logic             stallX,
    output logic [ADR_W-1:0] sram_adr,
    output logic [15:0]      sram_dout,
    input  logic [15:0]      sram_din,
    output logic             sram_doe,
    output logic             sram_ce_n,
    output logic             sram_oe_n,
    output logic             sram_we_n,
    output logic             sram_ub_n,
    output logic             sram_lb_n
`ifdef RISC5_SRAM_IO_BYPASS_EN
    ,
    output logic             io_sel
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_wr_q, op_ben_q;
    logic [ADR_W:0]     op_adr_q;
    logic [31:0]        op_data_q;
    logic [15:0]        lo_q, lo_d;

    logic [31:0]        inbus_d;
    logic               stall_d;
    logic [ADR_W-1:0]   adr_d;
    logic [15:0]        dout_d;
    logic               doe_d, ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;

    logic               idle, req, io_hit;
    logic               ph_en, ph_hi;
    logic [CNT_W-1:0]   ph_cnt;
    logic               p_wr, p_ben;
    logic [ADR_W:0]     p_adr;
    logic [31:0]        p_data;

    // Address bits above the SRAM window alias; keep them visibly consumed.
    logic               unused_adr_hi;
    assign unused_adr_hi = ^adr[23:ADR_W+1];

`ifdef RISC5_SRAM_IO_BYPASS_EN
    // IO page decode: requests to adr[23:6]=all ones never reach the SRAM.
    assign io_hit = &adr[23:6];
    assign io_sel = (rd | wr) & io_hit;
`else
    assign io_hit = 1'b0;
`endif

    assign idle = (state_q == IDLE);
    assign req  = (rd | wr) & ~io_hit;

    // Next state, phase sequencing and next-cycle pad/bus values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_d   = stallX;
        inbus_d   = inbus;
        lo_d      = lo_q;
        adr_d     = sram_adr;
        dout_d    = sram_dout;
        doe_d     = 1'b0;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        ub_n_d    = 1'b1;
        lb_n_d    = 1'b1;
        ph_en     = 1'b0;
        ph_hi     = 1'b0;
        ph_cnt    = '0;
        // In IDLE the phase being set up belongs to the incoming request.
        p_wr      = idle ? wr : op_wr_q;
        p_ben     = idle ? ben : op_ben_q;
        p_adr     = idle ? adr[ADR_W:0] : op_adr_q;
        p_data    = idle ? outbus : op_data_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LO;
                    cnt_d   = '0;
                    stall_d = 1'b1;
                    ph_en   = 1'b1;
                end
            end
            LO, HI: begin
                if (cnt_q != LAST) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    ph_en  = 1'b1;
                    ph_hi  = (state_q == HI);
                    ph_cnt = cnt_d;
                end else begin
                    cnt_d = '0;
                    if (!op_wr_q) begin
                        if (op_ben_q) begin
                            inbus_d = op_adr_q[1] ? {sram_din, 16'h0000} : {16'h0000, sram_din};
                        end else if (state_q == LO) begin
                            lo_d = sram_din;
                        end else begin
                            inbus_d = {sram_din, lo_q};
                        end
                    end
                    if (state_q == LO && !op_ben_q) begin
                        state_d = HI;
                        ph_en   = 1'b1;
                        ph_hi   = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                stall_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (ph_en) begin
            ce_n_d = 1'b0;
            if (p_ben) begin
                adr_d  = p_adr[ADR_W:1];
                ub_n_d = ~p_adr[0];
                lb_n_d = p_adr[0];
            end else begin
                adr_d  = {p_adr[ADR_W:2], ph_hi};
                ub_n_d = 1'b0;
                lb_n_d = 1'b0;
            end
            if (p_wr) begin
                doe_d  = 1'b1;
                we_n_d = (ph_cnt == LAST);
                dout_d = (p_ben ? p_adr[1] : ph_hi) ? p_data[31:16] : p_data[15:0];
            end else begin
                oe_n_d = 1'b0;
            end
        end
    end

    // State, phase counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lo_q      <= '0;
            inbus     <= '0;
            stallX    <= 1'b0;
            sram_adr  <= '0;
            sram_dout <= '0;
            sram_doe  <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lo_q      <= lo_d;
            inbus     <= inbus_d;
            stallX    <= stall_d;
            sram_adr  <= adr_d;
            sram_dout <= dout_d;
            sram_doe  <= doe_d;
            sram_ce_n <= ce_n_d;
            sram_oe_n <= oe_n_d;
            sram_we_n <= we_n_d;
            sram_ub_n <= ub_n_d;
            sram_lb_n <= lb_n_d;
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr_q   <= 1'b0;
            op_ben_q  <= 1'b0;
            op_adr_q  <= '0;
            op_data_q <= '0;
        end else if (idle && req) begin
            op_wr_q   <= wr;
            op_ben_q  <= ben;
            op_adr_q  <= adr[ADR_W:0];
            op_data_q <= outbus;
        end
    end

endmodule

// File: tb/tb_risc5_sram16_ctrl.sv
// Testbench for risc5_sram16_ctrl: directed plan cases plus random loads/stores
// checked against a transaction-level memory model.
module tb_risc5_sram16_ctrl;

    localparam int unsigned ADR_W = 19;
    localparam int unsigned W     = 1;
    localparam int unsigned MEM_N = 2048;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [23:0]      adr = '0;
    logic             rd = 1'b0, wr = 1'b0, ben = 1'b0;
    logic [31:0]      outbus = '0;
    logic [31:0]      inbus;
    logic             stallX;
    logic [ADR_W-1:0] sram_adr;
    logic [15:0]      sram_dout, sram_din;
    logic             sram_doe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
`ifdef RISC5_SRAM_IO_BYPASS_EN
    logic             io_sel;
`endif

    logic [15:0] sram_mem [0:(1<<ADR_W)-1];
    logic [15:0] ref_mem  [0:(1<<ADR_W)-1];
    logic [31:0] last_rd;
    int n_tests = 0;
    int n_fail  = 0;

    risc5_sram16_ctrl #(.ADR_W(ADR_W), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .adr(adr), .rd(rd), .wr(wr), .ben(ben),
        .outbus(outbus), .inbus(inbus), .stallX(stallX),
        .sram_adr(sram_adr), .sram_dout(sram_dout), .sram_din(sram_din),
        .sram_doe(sram_doe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
`ifdef RISC5_SRAM_IO_BYPASS_EN
        , .io_sel(io_sel)
`endif
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: read is combinational, write commits on the we_n rising edge.
    assign sram_din = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_adr] : 16'h0000;

    always @(posedge sram_we_n) begin
        if (rst && !sram_ce_n) begin
            if (!sram_lb_n) sram_mem[sram_adr][7:0]  = sram_dout[7:0];
            if (!sram_ub_n) sram_mem[sram_adr][15:8] = sram_dout[15:8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One CPU transaction, started at a negedge; returns at the negedge of the first IDLE cycle.
    task automatic do_txn(input logic t_rd, input logic t_wr, input logic t_ben,
                          input logic [23:0] a, input logic [31:0] d);
        logic             is_wr;
        int               phases, stall_n, ce_n_cnt, we_cnt, oe_cnt, guard;
        logic [ADR_W-1:0] idx_lo, idx_hi, first_adr, last_adr;
        logic [1:0]       lanes, exp_lanes;
        logic             seen;
        logic [15:0]      h;
        is_wr     = t_wr;
        phases    = t_ben ? 1 : 2;
        idx_lo    = t_ben ? a[ADR_W:1] : {a[ADR_W:2], 1'b0};
        idx_hi    = t_ben ? a[ADR_W:1] : {a[ADR_W:2], 1'b1};
        exp_lanes = t_ben ? (a[0] ? 2'b01 : 2'b10) : 2'b00;
        stall_n = 0; ce_n_cnt = 0; we_cnt = 0; oe_cnt = 0; guard = 0;
        seen = 1'b0; first_adr = '0; last_adr = '0; lanes = 2'b11;

        rd = t_rd; wr = t_wr; ben = t_ben; adr = a; outbus = d;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        while (stallX && guard < 64) begin
            stall_n++;
            if (!sram_ce_n) begin
                ce_n_cnt++;
                if (!seen) begin
                    first_adr = sram_adr;
                    lanes     = {sram_ub_n, sram_lb_n};
                    seen      = 1'b1;
                end
                last_adr = sram_adr;
            end
            if (!sram_we_n) we_cnt++;
            if (!sram_oe_n) oe_cnt++;
            // Requests while busy must be ignored; scramble the bus meanwhile.
            rd     = ($urandom_range(0, 3) == 0);
            wr     = ($urandom_range(0, 3) == 0);
            adr    = 24'($urandom);
            outbus = $urandom;
            ben    = 1'($urandom);
            @(negedge clk);
            guard++;
        end
        rd = 1'b0; wr = 1'b0;
        check("stall_timeout", 32'(guard >= 64), 32'd0);

        if (is_wr) begin
            if (t_ben) begin
                h = a[1] ? d[31:16] : d[15:0];
                if (a[0]) ref_mem[idx_lo][15:8] = h[15:8];
                else      ref_mem[idx_lo][7:0]  = h[7:0];
            end else begin
                ref_mem[idx_lo] = d[15:0];
                ref_mem[idx_hi] = d[31:16];
            end
        end else begin
            if (t_ben) last_rd = a[1] ? {ref_mem[idx_lo], 16'h0000} : {16'h0000, ref_mem[idx_lo]};
            else       last_rd = {ref_mem[idx_hi], ref_mem[idx_lo]};
        end

        check("stall_len", 32'(stall_n), 32'(phases * (W + 1) + 1));
        check("ce_cycles", 32'(ce_n_cnt), 32'(phases * (W + 1)));
        check("we_cycles", 32'(we_cnt), is_wr ? 32'(phases * W) : 32'd0);
        check("oe_cycles", 32'(oe_cnt), is_wr ? 32'd0 : 32'(phases * (W + 1)));
        check("adr_first", 32'(first_adr), 32'(idx_lo));
        check("adr_last", 32'(last_adr), 32'(idx_hi));
        check("lanes", 32'(lanes), 32'(exp_lanes));
        check("inbus", inbus, last_rd);
        if (is_wr) begin
            check("mem_lo", 32'(sram_mem[idx_lo]), 32'(ref_mem[idx_lo]));
            check("mem_hi", 32'(sram_mem[idx_hi]), 32'(ref_mem[idx_hi]));
        end
    endtask

    initial begin
        logic [15:0]  v;
        logic [23:0]  ra;
        int           op;
        logic         r_rd, r_wr, r_ben;

        for (int i = 0; i < int'(MEM_N); i++) begin
            v = 16'($urandom);
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        sram_mem[19'h00100] = 16'h5678; ref_mem[19'h00100] = 16'h5678;
        sram_mem[19'h00101] = 16'hABCD; ref_mem[19'h00101] = 16'hABCD;
        sram_mem[19'h00003] = 16'h12AB; ref_mem[19'h00003] = 16'h12AB;
        last_rd = '0;

        #3 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_inbus", inbus, 32'h0);
        check("rst_stall", 32'(stallX), 32'd0);
        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        check("rst_doe", 32'(sram_doe), 32'd0);
        check("rst_adr", 32'(sram_adr), 32'd0);
        check("rst_dout", 32'(sram_dout), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_txn(1'b1, 1'b0, 1'b0, 24'h000200, 32'h0);
        check("plan_word_rd", inbus, 32'hABCD5678);
        do_txn(1'b0, 1'b1, 1'b0, 24'h000204, 32'hDEADBEEF);
        check("plan_wr_lo", 32'(sram_mem[19'h00102]), 32'h0000BEEF);
        check("plan_wr_hi", 32'(sram_mem[19'h00103]), 32'h0000DEAD);
        check("plan_wr_inbus", inbus, 32'hABCD5678);
        do_txn(1'b1, 1'b0, 1'b1, 24'h000006, 32'h0);
        check("plan_byte_rd", inbus, 32'h12AB0000);
        do_txn(1'b0, 1'b1, 1'b1, 24'h000007, 32'h77777777);
        check("plan_byte_wr", 32'(sram_mem[19'h00003]), 32'h000077AB);
        do_txn(1'b1, 1'b1, 1'b0, 24'hF00204, 32'h13572468);
        check("rdwr_is_wr", 32'(sram_mem[19'h00102]), 32'h00002468);

        for (int t = 0; t < 40; t++) begin
            op    = int'($urandom_range(0, 3));
            ra    = {4'($urandom), 9'h000, 11'($urandom)};
            r_wr  = (op == 1 || op == 3);
            r_rd  = !r_wr || ($urandom_range(0, 3) == 0);
            r_ben = (op >= 2);
            do_txn(r_rd, r_wr, r_ben, ra, $urandom);
        end

        // Reset in the HI phase of a word read aborts it immediately.
        do_txn(1'b1, 1'b0, 1'b0, 24'h000200, 32'h0);
        rd = 1'b1; ben = 1'b0; adr = 24'h000200;
        @(negedge clk); rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_stall", 32'(stallX), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_stall", 32'(stallX), 32'd0);
        check("arst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        check("arst_doe", 32'(sram_doe), 32'd0);
        check("arst_inbus", inbus, 32'h0);
        last_rd = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(stallX), 32'd0);
        do_txn(1'b1, 1'b0, 1'b0, 24'h000204, 32'h0);

`ifdef RISC5_SRAM_IO_BYPASS_EN
        rd = 1'b1; adr = 24'hFFFFC4; ben = 1'b0;
        #1;
        check("io_sel", 32'(io_sel), 32'd1);
        @(negedge clk);
        rd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("io_stall", 32'(stallX), 32'd0);
            check("io_ce", 32'(sram_ce_n), 32'd1);
            @(negedge clk);
        end
        check("io_inbus", inbus, last_rd);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
